// File: rtl/jr_pkg.sv
// Shared types and pattern helpers for the ring/Johnson sequencing controller.
// Pattern helpers work on a 16-bit container masked down to the active width.
package jr_pkg;

    localparam int   JR_MAX_W     = 16;
    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } jr_state_e;

    function automatic logic [JR_MAX_W-1:0] jr_mask(input int w);
        return {JR_MAX_W{1'b1}} >> (JR_MAX_W - w);
    endfunction

    function automatic logic [JR_MAX_W-1:0] jr_seed(input logic mode, input int w);
        logic [JR_MAX_W-1:0] s;
        s = (mode == MODE_JOHNSON) ? '0 : JR_MAX_W'(1);
        return s & jr_mask(w);
    endfunction

    // Ring rotates the MSB back into bit 0; Johnson feeds back its inverse.
    function automatic logic [JR_MAX_W-1:0] jr_next(input logic [JR_MAX_W-1:0] s,
                                                    input logic mode, input int w);
        logic                msb;
        logic [JR_MAX_W-1:0] shl;
        msb = ((s >> (w - 1)) & JR_MAX_W'(1)) != '0;
        shl = s << 1;
        shl[0] = (mode == MODE_JOHNSON) ? ~msb : msb;
        return shl & jr_mask(w);
    endfunction

endpackage

// File: rtl/jr_expect.sv
// Expected-pattern model: loads the seed for the selected mode, then advances
// one step per cycle while adv_i is high.
module jr_expect
    import jr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] exp_o
);

    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_d;

    always_comb begin
        exp_d = exp_q;
        if (load_i) begin
            exp_d = WIDTH'(jr_seed(mode_i, WIDTH));
        end else if (adv_i) begin
            exp_d = WIDTH'(jr_next(JR_MAX_W'(exp_q), mode_i, WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q <= WIDTH'(jr_seed(MODE_RING, WIDTH));
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/jr_seq_ctrl.sv
// Sequencer that clears an external ring/Johnson counter, lets it run for a
// commanded number of steps and checks every state it presents.
//
//   state | meaning
//   IDLE  | ready for a command, counter held at seed
//   CLEAR | one cycle of counter clear with the new mode applied
//   RUN   | counter released, compared against the expected pattern
//   DONE  | one-cycle completion pulse
module jr_seq_ctrl
    import jr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [7:0]       cmd_steps,
    input  logic             abort,
    output logic             ctr_rstn,
    output logic             ctr_j_r,
    input  logic [WIDTH-1:0] ctr_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    jr_state_e        state_q;
    logic [7:0]       steps_q;
    logic             ctr_rstn_q;
    logic             ctr_j_r_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;
    logic [WIDTH-1:0] exp_val;
    logic             mismatch;

    jr_expect #(.WIDTH(WIDTH)) u_expect (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (state_q != ST_RUN),
        .adv_i  (state_q == ST_RUN),
        .mode_i (ctr_j_r_q),
        .exp_o  (exp_val)
    );

    assign mismatch = (state_q == ST_RUN) && (ctr_out != exp_val);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            steps_q    <= 8'd0;
            ctr_rstn_q <= 1'b0;
            ctr_j_r_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            done_q <= 1'b0;
            if (mismatch) begin
                err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        ctr_j_r_q <= cmd_mode;
                        steps_q   <= cmd_steps;
                        err_q     <= 1'b0;
                        err_cnt_q <= 8'd0;
                        state_q   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (steps_q == 8'd0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_RUN;
                        ctr_rstn_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // steps_q counts RUN cycles still to go, including this one
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        ctr_rstn_q <= 1'b0;
                    end else if (steps_q == 8'd1) begin
                        state_q    <= ST_DONE;
                        ctr_rstn_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        steps_q <= steps_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ctr_rstn_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rstn so the controller never advertises ready while held in reset.
    assign cmd_ready = rstn && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ctr_rstn  = ctr_rstn_q;
    assign ctr_j_r   = ctr_j_r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
